// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver: captures a packed hex value,
// commits it only at frame boundaries and scans digits with a dark guard slot.
module display_scan_mux #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  lz_en,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0] PC_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PC_GUARD = PW'(GUARD);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [PW-1:0]         pcnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   pend_value, act_value;
   logic [DIGITS-1:0]     pend_dp, act_dp;
   logic [DIGITS-1:0]     pend_blank, act_blank;
   logic                  pend_v;

   logic                  tc;
   logic                  boundary;
   logic [3:0]            nib;
   logic                  dp_sel;
   logic                  blank_sel;
   logic                  lz_dark;
   logic                  hi_zero;
   logic [7:0]            seg_d;
   logic [DIGITS-1:0]     an_d;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   assign tc       = (pcnt == PC_LAST);
   assign boundary = tc && (idx == IDX_LAST);

   always_comb begin
      nib       = 4'h0;
      dp_sel    = 1'b0;
      blank_sel = 1'b0;
      lz_dark   = 1'b0;
      hi_zero   = 1'b1;
      seg_d     = 8'hFF;
      an_d      = '1;
      // Walk from the most significant digit so hi_zero covers nibbles k..DIGITS-1.
      for (int k = DIGITS - 1; k >= 0; k--) begin
         hi_zero = hi_zero && (act_value[4*k +: 4] == 4'h0);
         if (idx == IW'(k)) begin
            nib       = act_value[4*k +: 4];
            dp_sel    = act_dp[k];
            blank_sel = act_blank[k];
            lz_dark   = lz_en && hi_zero && (k != 0);
            if (pcnt >= PC_GUARD) an_d[k] = 1'b0;
         end
      end
      if ((pcnt >= PC_GUARD) && !blank_sel && !lz_dark)
         seg_d = {~dp_sel, hex7(nib)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
         idx  <= '0;
      end else if (tc) begin
         pcnt <= '0;
         idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_value <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_v     <= 1'b0;
         act_value  <= '0;
         act_dp     <= '0;
         act_blank  <= '0;
      end else if (boundary) begin
         // A load landing on the boundary bypasses pending so it is not delayed a frame.
         pend_v <= 1'b0;
         if (load) begin
            act_value <= value;
            act_dp    <= dp;
            act_blank <= blank;
         end else if (pend_v) begin
            act_value <= pend_value;
            act_dp    <= pend_dp;
            act_blank <= pend_blank;
         end
      end else if (load) begin
         pend_value <= value;
         pend_dp    <= dp;
         pend_blank <= blank;
         pend_v     <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg   <= 8'hFF;
         an    <= '1;
         frame <= 1'b0;
      end else begin
         seg   <= seg_d;
         an    <= an_d;
         frame <= boundary;
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: stimulus pushes expected {an,seg} per
// digit slot; the monitor pops one entry at every slot start.
module tb_display_scan_mux;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 8;
   localparam int GUARD    = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        load  = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp    = '0;
   logic [3:0]  blank = '0;
   logic        lz_en = 1'b0;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame;

   int          tests = 0;
   int          fails = 0;
   logic [11:0] exp_q[$];
   bit          mon_en = 1'b1;

   display_scan_mux #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV),
      .GUARD    (GUARD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .value (value),
      .dp    (dp),
      .blank (blank),
      .lz_en (lz_en),
      .seg   (seg),
      .an    (an),
      .frame (frame)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers / drivers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push4(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
      exp_q.push_back({4'b1110, d0});
      exp_q.push_back({4'b1101, d1});
      exp_q.push_back({4'b1011, d2});
      exp_q.push_back({4'b0111, d3});
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      value = v;
      dp    = d;
      blank = b;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic wait_frame();
      bit got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (frame === 1'b1) got = 1'b1;
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL frame_timeout: no frame pulse within 100 cycles, expected one");
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [3:0]  prev_an   = 4'hF;
   logic [7:0]  slot_seg  = 8'hFF;
   int          guard_cnt = 0;
   logic [11:0] exp_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_an   = 4'hF;
         guard_cnt = 0;
      end else if (mon_en) begin
         if (an == 4'hF) begin
            guard_cnt++;
            check("guard_seg", seg, 8'hFF);
         end else begin
            check("an_onehot", $countones(~an), 1);
            if (prev_an == 4'hF) begin
               check("guard_len", guard_cnt, GUARD);
               guard_cnt = 0;
               slot_seg  = seg;
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL slot_underflow: got an=%b seg=%h with no expected entry", an, seg);
               end else begin
                  exp_e = exp_q.pop_front();
                  check("slot", {an, seg}, exp_e);
               end
            end else begin
               check("slot_stable", {an, seg}, {prev_an, slot_seg});
            end
         end
         if (frame) check("frame_align", an, 4'b0111);
         prev_an = an;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit seen;
      #1 rst_n = 1'b0;
      #1;
      check("rst_seg", seg, 8'hFF);
      check("rst_an", an, 4'hF);
      check("rst_frame", frame, 1'b0);

      // Frame A: cleared active value, no blanking
      push4(8'hC0, 8'hC0, 8'hC0, 8'hC0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      // Mid-frame load must not show until the next frame
      repeat (10) @(negedge clk);
      do_load(16'h3A7F, 4'b0100, 4'b0000);
      push4(8'h8E, 8'hF8, 8'h08, 8'hB0);
      wait_frame();

      // Leading-zero blanking
      repeat (4) @(negedge clk);
      lz_en = 1'b1;
      do_load(16'h0050, 4'b0000, 4'b0000);
      push4(8'hC0, 8'h92, 8'hFF, 8'hFF);
      wait_frame();

      repeat (4) @(negedge clk);
      do_load(16'h0000, 4'b0000, 4'b0000);
      push4(8'hC0, 8'hFF, 8'hFF, 8'hFF);
      wait_frame();

      // Two loads in one frame: last wins
      repeat (3) @(negedge clk);
      do_load(16'h1111, 4'b0000, 4'b0000);
      repeat (5) @(negedge clk);
      do_load(16'h2222, 4'b0000, 4'b0000);
      push4(8'hA4, 8'hA4, 8'hA4, 8'hA4);
      wait_frame();

      // Pending 1234, then a load in the boundary cycle itself overrides it
      repeat (2) @(negedge clk);
      do_load(16'h1234, 4'b0000, 4'b0000);
      exp_q.push_back({4'b1110, 8'h8E});
      exp_q.push_back({4'b1101, 8'hFF});
      exp_q.push_back({4'b1011, 8'h86});
      // after the mid-slot reset: active cleared, lz_en still on
      push4(8'hC0, 8'hFF, 8'hFF, 8'hFF);
      repeat (28) @(negedge clk);
      value = 16'hBEEF;
      dp    = 4'b0000;
      blank = 4'b0010;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      check("boundary_frame", frame, 1'b1);

      // Reset pulse in the middle of digit 2's slot
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         if (an == 4'b1011) seen = 1'b1;
      end
      check("digit2_seen", seen, 1'b1);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_seg", seg, 8'hFF);
      check("async_rst_an", an, 4'hF);
      check("async_rst_frame", frame, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      wait_frame();
      mon_en = 1'b0;
      check("queue_drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
